// File: rtl/limit_switch_conditioner_pkg.sv
// Purpose : register offsets and STATUS bit positions for the limit switch conditioner.
// Latency : n/a (constants only).
// Backpressure: n/a.
package limit_switch_conditioner_pkg;

   // Register offsets, decoded from PADDR[7:0]
   localparam logic [7:0] ADDR_STATUS    = 8'h00;
   localparam logic [7:0] ADDR_TRIP_CLR  = 8'h04;
   localparam logic [7:0] ADDR_IRQ_EN    = 8'h08;
   localparam logic [7:0] ADDR_TRIP_CNT0 = 8'h0C;
   localparam logic [7:0] ADDR_TRIP_CNT1 = 8'h10;
   localparam logic [7:0] ADDR_CNT_CLR   = 8'h14;

   // STATUS layout
   localparam int STATUS_DB_LSB     = 0;   // [1:0] debounced levels
   localparam int STATUS_STICKY_LSB = 4;   // [5:4] sticky trip flags
   localparam int STATUS_IRQ_BIT    = 8;   // [8]   interrupt line

endpackage

// File: rtl/limit_switch_conditioner_debounce_channel.sv
// Purpose : one limit-switch channel: 2-flop synchroniser, stability counter, clean level, trip pulse.
// Latency : pin to db = DEBOUNCE_CYCLES+2 cycles; fall pulse one cycle after db drops.
// Backpressure: none; free-running every cycle.
// Ports   : clk, rst_n (async active-low), raw (async switch pin),
//           db (debounced level, resets to 0 = tripped), fall (1-cycle pulse on db 1->0).
module debounce_channel #(
   parameter int DEBOUNCE_CYCLES = 100000,
   parameter int CNT_W           = 17
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic db,
   output logic fall
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             meta;
   logic             s;
   logic             db_d1;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta  <= 1'b0;
         s     <= 1'b0;
         db    <= 1'b0;
         db_d1 <= 1'b0;
         cnt   <= '0;
      end else begin
         meta  <= raw;
         s     <= meta;
         db_d1 <= db;
         // Count consecutive cycles of disagreement; the last one flips the level,
         // so a change is accepted after exactly DEBOUNCE_CYCLES stable cycles.
         if (s == db) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            db  <= ~db;
            cnt <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   // Registered edge detect: both terms are flops, so no combinational path from the pin.
   assign fall = db_d1 & ~db;

endmodule

// File: rtl/limit_switch_conditioner.sv
// Purpose : APB3 limit-switch conditioner feeding the servo stop_y kill inputs, with sticky flags, trip counters, irq.
// Latency : pin to sw_db = DEBOUNCE_CYCLES+2; sticky/counters update one cycle after sw_db falls; reads are combinational.
// Backpressure: none; PREADY tied high, PSLVERR tied low.
// Ports   : PCLK/PRESERN (async active-low), APB3 slave (PSEL, PENABLE, PWRITE, PADDR, PWDATA, PRDATA, PREADY, PSLVERR),
//           sw_raw[1:0] raw active-low switches ([1] upper, [0] lower), sw_db[1:0] debounced levels, irq.
module limit_switch_conditioner
   import limit_switch_conditioner_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 100000,
   parameter int CNT_W           = 17,
   parameter int TRIP_W          = 16
) (
   input  logic        PCLK,
   input  logic        PRESERN,
   input  logic        PSEL,
   input  logic        PENABLE,
   input  logic        PWRITE,
   input  logic [31:0] PADDR,
   input  logic [31:0] PWDATA,
   output logic [31:0] PRDATA,
   output logic        PREADY,
   output logic        PSLVERR,
   input  logic [1:0]  sw_raw,
   output logic [1:0]  sw_db,
   output logic        irq
);

   logic [1:0]        fall;
   logic [1:0]        sticky;
   logic [1:0]        irq_en;
   logic [TRIP_W-1:0] trip_cnt [2];
   logic [7:0]        addr;
   logic              wr_en;
   logic              rd_en;
   logic [1:0]        trip_clr;
   logic [1:0]        cnt_clr;
   logic              unused_apb;

   assign PREADY  = 1'b1;
   assign PSLVERR = 1'b0;

   for (genvar i = 0; i < 2; i++) begin : g_ch
      debounce_channel #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .CNT_W           (CNT_W)
      ) u_ch (
         .clk   (PCLK),
         .rst_n (PRESERN),
         .raw   (sw_raw[i]),
         .db    (sw_db[i]),
         .fall  (fall[i])
      );
   end

   assign addr       = PADDR[7:0];
   assign wr_en      = PSEL & PWRITE & PENABLE;
   assign rd_en      = PSEL & ~PWRITE;
   assign trip_clr   = (wr_en && addr == ADDR_TRIP_CLR) ? PWDATA[1:0] : 2'b00;
   assign cnt_clr    = (wr_en && addr == ADDR_CNT_CLR)  ? PWDATA[1:0] : 2'b00;
   assign unused_apb = ^{PADDR[31:8], PWDATA[31:2]};

   always_ff @(posedge PCLK or negedge PRESERN) begin
      if (!PRESERN) begin
         sticky      <= 2'b00;
         irq_en      <= 2'b00;
         trip_cnt[0] <= '0;
         trip_cnt[1] <= '0;
      end else begin
         if (wr_en && addr == ADDR_IRQ_EN) begin
            irq_en <= PWDATA[1:0];
         end
         // A trip arriving with a clear on the same bit wins.
         sticky <= (sticky & ~trip_clr) | fall;
         for (int i = 0; i < 2; i++) begin
            if (fall[i]) begin
               if (cnt_clr[i]) begin
                  trip_cnt[i] <= TRIP_W'(1);
               end else if (trip_cnt[i] != '1) begin
                  trip_cnt[i] <= trip_cnt[i] + 1'b1;
               end
            end else if (cnt_clr[i]) begin
               trip_cnt[i] <= '0;
            end
         end
      end
   end

   assign irq = |(sticky & irq_en);

   always_comb begin
      PRDATA = '0;
      if (rd_en) begin
         case (addr)
            ADDR_STATUS: begin
               PRDATA[STATUS_DB_LSB +: 2]     = sw_db;
               PRDATA[STATUS_STICKY_LSB +: 2] = sticky;
               PRDATA[STATUS_IRQ_BIT]         = irq;
            end
            ADDR_IRQ_EN:    PRDATA[1:0]        = irq_en;
            ADDR_TRIP_CNT0: PRDATA[TRIP_W-1:0] = trip_cnt[0];
            ADDR_TRIP_CNT1: PRDATA[TRIP_W-1:0] = trip_cnt[1];
            default:        PRDATA             = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_limit_switch_conditioner.sv
module tb_limit_switch_conditioner;
   import limit_switch_conditioner_pkg::*;

   localparam int DB       = 8;
   localparam int TRIP_MAX = 15;

   logic        PCLK;
   logic        PRESERN;
   logic        PSEL;
   logic        PENABLE;
   logic        PWRITE;
   logic [31:0] PADDR;
   logic [31:0] PWDATA;
   logic [31:0] PRDATA;
   logic        PREADY;
   logic        PSLVERR;
   logic [1:0]  sw_raw;
   logic [1:0]  sw_db;
   logic        irq;

   int checks   = 0;
   int failures = 0;

   // Reference model state
   logic [1:0] m_db;
   logic [1:0] m_s1;
   logic [1:0] m_s2;
   logic [1:0] m_fall;
   logic [1:0] m_sticky;
   logic [1:0] m_irq_en;
   int         m_run [2];
   int         m_cnt [2];
   int         hold  [2];

   limit_switch_conditioner #(
      .DEBOUNCE_CYCLES (DB),
      .CNT_W           (4),
      .TRIP_W          (4)
   ) dut (
      .PCLK    (PCLK),
      .PRESERN (PRESERN),
      .PSEL    (PSEL),
      .PENABLE (PENABLE),
      .PWRITE  (PWRITE),
      .PADDR   (PADDR),
      .PWDATA  (PWDATA),
      .PRDATA  (PRDATA),
      .PREADY  (PREADY),
      .PSLVERR (PSLVERR),
      .sw_raw  (sw_raw),
      .sw_db   (sw_db),
      .irq     (irq)
   );

   initial begin
      PCLK = 1'b0;
      forever #5 PCLK = ~PCLK;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_db = 2'b00; m_s1 = 2'b00; m_s2 = 2'b00; m_fall = 2'b00;
      m_sticky = 2'b00; m_irq_en = 2'b00;
      for (int i = 0; i < 2; i++) begin
         m_run[i] = 0;
         m_cnt[i] = 0;
      end
   endtask

   function automatic logic m_irq();
      return |(m_sticky & m_irq_en);
   endfunction

   function automatic logic [31:0] model_read(input logic [7:0] a);
      logic [31:0] r;
      r = 32'h0;
      case (a)
         8'h00: r = 32'(m_db) | (32'(m_sticky) << 4) | (32'(m_irq()) << 8);
         8'h08: r = 32'(m_irq_en);
         8'h0C: r = 32'(m_cnt[0]);
         8'h10: r = 32'(m_cnt[1]);
         default: r = 32'h0;
      endcase
      return r;
   endfunction

   // One clock edge; the model applies the rules to the inputs seen at that edge.
   task automatic tick();
      logic [1:0]  raw_now;
      logic        wr;
      logic [7:0]  a;
      logic [31:0] d;
      logic        old_db;
      raw_now = sw_raw;
      wr      = PSEL & PENABLE & PWRITE;
      a       = PADDR[7:0];
      d       = PWDATA;
      @(posedge PCLK);
      if (wr && a == 8'h08) m_irq_en = d[1:0];
      for (int i = 0; i < 2; i++) begin
         if (wr && a == 8'h04 && d[i]) m_sticky[i] = 1'b0;
         if (m_fall[i]) m_sticky[i] = 1'b1;
         if (wr && a == 8'h14 && d[i]) m_cnt[i] = 0;
         if (m_fall[i]) m_cnt[i] = (m_cnt[i] < TRIP_MAX) ? m_cnt[i] + 1 : TRIP_MAX;
         old_db = m_db[i];
         if (m_s2[i] != m_db[i]) begin
            m_run[i]++;
            if (m_run[i] == DB) begin
               m_db[i]  = ~m_db[i];
               m_run[i] = 0;
            end
         end else begin
            m_run[i] = 0;
         end
         m_fall[i] = old_db & ~m_db[i];
         m_s2[i]   = m_s1[i];
         m_s1[i]   = raw_now[i];
      end
      #1;
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
      PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = 32'(a); PWDATA = d;
      tick();
      PENABLE = 1'b1;
      tick();
      PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 32'h0; PWDATA = 32'h0;
   endtask

   task automatic apb_read(input logic [7:0] a, output logic [31:0] d);
      PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = 32'(a);
      #1;
      d = PRDATA;
      PSEL = 1'b0; PADDR = 32'h0;
   endtask

   task automatic check_reg(input string tag, input logic [7:0] a);
      logic [31:0] d;
      apb_read(a, d);
      check(tag, d, model_read(a));
   endtask

   task automatic check_all(input string tag);
      check({tag, "_db"}, 32'(sw_db), 32'(m_db));
      check({tag, "_irq"}, 32'(irq), 32'(m_irq()));
      check_reg({tag, "_status"}, ADDR_STATUS);
      check_reg({tag, "_irqen"}, ADDR_IRQ_EN);
      check_reg({tag, "_cnt0"}, ADDR_TRIP_CNT0);
      check_reg({tag, "_cnt1"}, ADDR_TRIP_CNT1);
   endtask

   initial begin
      logic [31:0] rd;
      logic [7:0]  wa;
      PRESERN = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
      PADDR = 32'h0; PWDATA = 32'h0; sw_raw = 2'b11;
      model_reset();

      // 1. Reset release with switches open
      @(posedge PCLK); #1;
      @(posedge PCLK); #1;
      check("rst_db", 32'(sw_db), 32'h0);
      apb_read(ADDR_STATUS, rd);
      check("rst_status", rd, 32'h0);
      check("pready", 32'(PREADY), 32'h1);
      check("pslverr", 32'(PSLVERR), 32'h0);
      PRESERN = 1'b1;
      model_reset();
      ticks(9);
      check("rel_9_db", 32'(sw_db), 32'h0);
      check("rel_9_model", 32'(sw_db), 32'(m_db));
      tick();
      check("rel_10_db", 32'(sw_db), 32'h3);
      apb_read(ADDR_STATUS, rd);
      check("rel_status", rd, 32'h003);
      check_all("rel");

      // 2. Glitch of 7 cycles is rejected
      ticks(4);
      sw_raw = 2'b10;
      ticks(7);
      sw_raw = 2'b11;
      ticks(12);
      check("glitch_db", 32'(sw_db), 32'h3);
      check_all("glitch");

      // 3. Trip on switch 0 with irq enabled, then clear
      apb_write(ADDR_IRQ_EN, 32'h1);
      sw_raw = 2'b10;
      ticks(9);
      check("trip0_9_db", 32'(sw_db), 32'h3);
      tick();
      check("trip0_10_db", 32'(sw_db), 32'h2);
      tick();
      apb_read(ADDR_STATUS, rd);
      check("trip0_status", rd, 32'h112);
      apb_read(ADDR_TRIP_CNT0, rd);
      check("trip0_cnt0", rd, 32'h1);
      check("trip0_irq", 32'(irq), 32'h1);
      check_all("trip0");
      sw_raw = 2'b11;
      apb_write(ADDR_TRIP_CLR, 32'h1);
      check("clr_irq", 32'(irq), 32'h0);
      apb_read(ADDR_STATUS, rd);
      check("clr_status", rd, 32'h002);
      ticks(12);

      // 4. Saturating trip counter on switch 1
      for (int t = 0; t < 17; t++) begin
         sw_raw = 2'b01;
         ticks(11);
         sw_raw = 2'b11;
         ticks(11);
      end
      apb_read(ADDR_TRIP_CNT1, rd);
      check("sat_cnt1", rd, 32'hF);
      check_all("sat");
      apb_write(ADDR_CNT_CLR, 32'h2);
      apb_read(ADDR_TRIP_CNT1, rd);
      check("cntclr_cnt1", rd, 32'h0);
      apb_write(ADDR_TRIP_CLR, 32'h2);
      check_all("cntclr");

      // 5a. TRIP_CLR coincident with a switch-0 trip edge: set wins
      sw_raw = 2'b10;
      ticks(9);
      PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0;
      PADDR = 32'(ADDR_TRIP_CLR); PWDATA = 32'h1;
      tick();
      check("coin_db", 32'(sw_db), 32'h2);
      PENABLE = 1'b1;
      tick();
      PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 32'h0; PWDATA = 32'h0;
      apb_read(ADDR_STATUS, rd);
      check("coin_sticky", (rd >> 4) & 32'h3, 32'h1);
      check_all("coin_clr");
      sw_raw = 2'b11;
      ticks(12);

      // 5b. CNT_CLR coincident with a switch-0 trip edge: counter becomes 1
      sw_raw = 2'b10;
      ticks(9);
      PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0;
      PADDR = 32'(ADDR_CNT_CLR); PWDATA = 32'h1;
      tick();
      PENABLE = 1'b1;
      tick();
      PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 32'h0; PWDATA = 32'h0;
      apb_read(ADDR_TRIP_CNT0, rd);
      check("coin_cnt0", rd, 32'h1);
      check_all("coin_cnt");
      sw_raw = 2'b11;
      ticks(12);
      apb_write(ADDR_TRIP_CLR, 32'h3);

      // 6. Reset mid-debounce, then full requalification
      sw_raw = 2'b10;
      ticks(7);
      PRESERN = 1'b0;
      #1;
      check("midrst_db", 32'(sw_db), 32'h0);
      model_reset();
      sw_raw = 2'b11;
      @(posedge PCLK); #1;
      PRESERN = 1'b1;
      ticks(9);
      check("rerel_9_db", 32'(sw_db), 32'h0);
      tick();
      check("rerel_10_db", 32'(sw_db), 32'h3);
      apb_read(8'h40, rd);
      check("unmapped", rd, 32'h0);
      apb_read(ADDR_TRIP_CLR, rd);
      check("trip_clr_read", rd, 32'h0);
      check_all("rerel");

      // Randomised phase: random switch activity and register writes against the model
      hold[0] = 0;
      hold[1] = 0;
      for (int c = 0; c < 600; c++) begin
         for (int i = 0; i < 2; i++) begin
            if (hold[i] == 0) begin
               sw_raw[i] = 1'($urandom_range(0, 1));
               hold[i]   = $urandom_range(1, 14);
            end else begin
               hold[i]--;
            end
         end
         if ($urandom_range(0, 19) == 0) begin
            case ($urandom_range(0, 3))
               0:       wa = ADDR_IRQ_EN;
               1:       wa = ADDR_TRIP_CLR;
               2:       wa = ADDR_CNT_CLR;
               default: wa = ADDR_STATUS;
            endcase
            apb_write(wa, 32'($urandom_range(0, 3)));
         end else begin
            tick();
         end
         check("rnd_db", 32'(sw_db), 32'(m_db));
         check("rnd_irq", 32'(irq), 32'(m_irq()));
         if (c % 25 == 0) check_all("rnd");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/limit_switch_conditioner.md
Name: limit_switch_conditioner

Overview:
APB3 peripheral that sits directly upstream of the servo controller's kill-switch inputs (stop_y[1:0], active-low: 0 = tripped). It synchronises and debounces the two raw Y-axis limit switches and drives the clean levels to the servo controller. It also latches sticky trip flags, counts trip events per switch and raises a maskable interrupt so firmware can see which end stop fired.

Parameters:
DEBOUNCE_CYCLES, 100000, consecutive stable cycles required to accept a level change (1 ms @ 100 MHz); must be >= 2
CNT_W, 17, width of the debounce counter; must hold DEBOUNCE_CYCLES
TRIP_W, 16, width of each saturating trip counter

Ports:
PCLK  in  1  clock
PRESERN  in  1  reset, asynchronous, active-low
PSEL  in  1  APB peripheral select
PENABLE  in  1  APB access phase
PWRITE  in  1  APB write/read
PADDR  in  32  APB address; only [7:0] decoded
PWDATA  in  32  APB write data
PRDATA  out  32  APB read data
PREADY  out  1  tied 1
PSLVERR  out  1  tied 0
sw_raw  in  2  raw switch inputs, asynchronous, active-low; [1] upper, [0] lower
sw_db  out  2  debounced levels, active-low; connects to servo stop_y
irq  out  1  interrupt, active-high

Behaviour:
- Reset: one clock, PCLK; reset is asynchronous and active-low on PRESERN. All flops clear asynchronously.
- Reset values: sync flops 0; sw_db = 2'b00 (tripped, which is the safe state); sticky = 0; irq_en = 0; trip counters = 0; debounce counters = 0; irq = 0.
- Synchroniser: each sw_raw bit passes through two flops to give s[i].
- Debounce, per channel (sub-module):
  - Counter increments each cycle while s[i] != sw_db[i].
  - Counter clears to 0 in any cycle where s[i] == sw_db[i].
  - When the counter reaches DEBOUNCE_CYCLES-1 while the levels still differ, sw_db[i] toggles on the next edge and the counter clears.
  - Net effect: a change seen at the sync output is accepted after exactly DEBOUNCE_CYCLES stable cycles. Pin-to-sw_db latency is DEBOUNCE_CYCLES+2.
  - A glitch shorter than DEBOUNCE_CYCLES produces no output change.
- Post-reset release: with the switches open, sw_db goes to 1 DEBOUNCE_CYCLES+2 cycles after PRESERN deasserts. This is not a trip event.
- Trip event: a 1->0 transition of sw_db[i] (registered edge detect, one cycle after the sw_db change).
  - Sets sticky[i].
  - Increments trip_cnt[i], saturating at all-ones.
- Register map (PADDR[7:0]); write strobe = PSEL & PWRITE & PENABLE:
  - 0x00 STATUS, R: [1:0] sw_db, [5:4] sticky, [8] irq; other bits 0.
  - 0x04 TRIP_CLR, W: bit i = 1 clears sticky[i]; reads 0.
  - 0x08 IRQ_EN, R/W: [1:0].
  - 0x0C TRIP_CNT0, R: zero-extended trip_cnt[0].
  - 0x10 TRIP_CNT1, R: zero-extended trip_cnt[1].
  - 0x14 CNT_CLR, W: bit i = 1 clears trip_cnt[i]; reads 0.
- Reads: PRDATA is combinational from registers when PSEL & !PWRITE. Unmapped addresses and idle cycles return 0. Writes to unmapped or read-only addresses are ignored.
- irq = OR over i of (sticky[i] & irq_en[i]), driven from flops with no extra latency.
- Simultaneous events:
  - Trip and TRIP_CLR on the same bit, same cycle: the set wins, sticky stays 1.
  - Trip and CNT_CLR on the same counter, same cycle: counter = 1.
- Reset mid-debounce: the counter is discarded and sw_db returns to 0 immediately (asynchronously).

Decomposition:
- Shared package: register offset constants (STATUS, TRIP_CLR, IRQ_EN, TRIP_CNT0/1, CNT_CLR) and the STATUS bit-position constants.
- One sub-module: debounce_channel (synchroniser + counter + level register + falling-edge pulse output), instantiated twice.

Test Plan (bench uses DEBOUNCE_CYCLES=8, TRIP_W=4):
1. Reset release, sw_raw=2'b11 -> sw_db=00 during reset; sw_db=11 exactly 10 cycles after PRESERN rises; STATUS reads 0x003; sticky=0, TRIP_CNT0=0.
2. sw_raw[0] low for 7 cycles then high -> sw_db stays 11; no count, no irq.
3. IRQ_EN=0x1, then sw_raw[0] held low -> sw_db[0]=0 after 10 cycles; next cycle STATUS=0x112, TRIP_CNT0=1, irq=1; write TRIP_CLR=0x1 -> irq=0, STATUS=0x002.
4. 17 trips on switch 1 -> TRIP_CNT1 saturates at 0xF; CNT_CLR=0x2 -> TRIP_CNT1=0.
5. TRIP_CLR=0x1 written in the same cycle as a switch-0 trip edge -> sticky[0]=1; CNT_CLR=0x1 in the same cycle -> TRIP_CNT0=1.
6. PRESERN pulsed low at debounce count 5 -> sw_db=00 immediately; after release, the full 10-cycle qualify restarts; unmapped read 0x40 -> PRDATA=0.
